alu_flag_stage: RTL and testbench

ALU_FLAG_STAGE -- requirements
Module: alu_flag_stage

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/cond_eval.sv | 38 +++
 rtl/alu_flag_stage.sv | 89 ++++++++
 tb/tb_alu_flag_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the ALU flag stage: condition codes, NZCV
//               flag layout and the buffered entry format.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_DATA_W = 64;
    localparam int c_DEPTH  = 2;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // One buffered entry: 64-bit result plus its condition outcome.
    typedef struct packed {
        logic [c_DATA_W-1:0] result;
        logic                cond_true;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational evaluation of a condition code against NZCV.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_eval
    import alu_pkg::*;
(
    input  cond_t cond,
    input  nzcv_t nzcv,
    output logic  true
);

    always_comb begin
        true = 1'b0;
        case (cond)
            COND_EQ: true = nzcv.z;
            COND_NE: true = !nzcv.z;
            COND_HS: true = nzcv.c;
            COND_LO: true = !nzcv.c;
            COND_MI: true = nzcv.n;
            COND_PL: true = !nzcv.n;
            COND_VS: true = nzcv.v;
            COND_VC: true = !nzcv.v;
            COND_HI: true = nzcv.c && !nzcv.z;
            COND_LS: true = !(nzcv.c && !nzcv.z);
            COND_GE: true = (nzcv.n == nzcv.v);
            COND_LT: true = (nzcv.n != nzcv.v);
            COND_GT: true = !nzcv.z && (nzcv.n == nzcv.v);
            COND_LE: true = !(!nzcv.z && (nzcv.n == nzcv.v));
            // NV behaves as always-true, same as AL.
            default: true = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_flag_stage
// Description : Two-entry result buffer that derives NZCV from the adder
//               output, maintains the flags register and evaluates conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_stage
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [c_DATA_W-1:0] sum,
    input  logic [c_DATA_W-1:0] carry,
    input  logic                set_flags,
    input  logic [3:0]          cond,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [c_DATA_W-1:0] result,
    output logic                cond_true,
    output logic [3:0]          flags
);

    logic [1:0] r_count;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    entry_t     r_mem [c_DEPTH];
    nzcv_t      r_flags;

    logic       w_push;
    logic       w_pop;
    nzcv_t      w_cand;
    nzcv_t      w_eval_flags;
    logic       w_cond_true;

    assign in_ready  = (r_count < 2'(c_DEPTH));
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_cand.n = sum[c_DATA_W-1];
        w_cand.z = (sum == '0);
        w_cand.c = carry[c_DATA_W-1];
        w_cand.v = carry[c_DATA_W-1] ^ carry[c_DATA_W-2];
    end

    // A flag-setting op is judged on the flags it produces, not the old ones.
    assign w_eval_flags = set_flags ? w_cand : r_flags;

    cond_eval u_cond_eval (
        .cond (cond_t'(cond)),
        .nzcv (w_eval_flags),
        .true (w_cond_true)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_flags  <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{result: sum, cond_true: w_cond_true};
                r_wr_ptr        <= ~r_wr_ptr;
                if (set_flags) begin
                    r_flags <= w_cand;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Cleared storage makes the head read back as zero until the first entry.
    assign result    = r_mem[r_rd_ptr].result;
    assign cond_true = r_mem[r_rd_ptr].cond_true;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_flag_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_flag_stage
// Description : Self-checking bench for alu_flag_stage using a queue-based
//               reference model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_flag_stage;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] sum;
    logic [63:0] carry;
    logic        set_flags;
    logic [3:0]  cond;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        cond_true;
    logic [3:0]  flags;

    logic [3:0]  ce_cond;
    logic [3:0]  ce_nzcv;
    logic        ce_true;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    alu_flag_stage dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .set_flags (set_flags),
        .cond      (cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cond_true (cond_true),
        .flags     (flags)
    );

    cond_eval u_ce (
        .cond (cond_t'(ce_cond)),
        .nzcv (nzcv_t'(ce_nzcv)),
        .true (ce_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ARM rule: pairs of codes share a base test, odd codes invert it, 15 is always.
    function automatic bit ref_cond(input int c, input logic [3:0] f);
        bit n, z, cc, v, base;
        {n, z, cc, v} = f;
        case (c / 2)
            0:       base = z;
            1:       base = cc;
            2:       base = n;
            3:       base = v;
            4:       base = cc && !z;
            5:       base = (n == v);
            6:       base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 15) return 1'b1;
        return (c % 2 == 1) ? !base : base;
    endfunction

    typedef struct {
        logic [63:0] r;
        bit          ct;
    } ment_t;

    ment_t      mq[$];
    logic [3:0] m_flags = 4'b0;
    bit         m_fresh = 1'b1;
    logic [3:0] m_cand;
    logic [3:0] m_use;
    bit         m_acc;
    bit         m_pop;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_flags = 4'b0;
            m_fresh = 1'b1;
        end else begin
            m_acc  = in_valid && (mq.size() < 2);
            m_pop  = out_ready && (mq.size() > 0);
            m_cand = {sum[63], sum == 64'd0, carry[63], carry[63] ^ carry[62]};
            m_use  = set_flags ? m_cand : m_flags;
            if (m_pop) void'(mq.pop_front());
            if (m_acc) begin
                mq.push_back('{sum, ref_cond(int'(cond), m_use)});
                if (set_flags) m_flags = m_cand;
                m_fresh = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
            chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
            chk("flags", {60'd0, flags}, {60'd0, m_flags});
            if (mq.size() != 0) begin
                chk("result", result, mq[0].r);
                chk("cond_true", {63'd0, cond_true}, {63'd0, mq[0].ct});
            end else if (m_fresh) begin
                chk("result_after_reset", result, 64'd0);
                chk("cond_true_after_reset", {63'd0, cond_true}, 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input bit v, input logic [63:0] s, input logic [63:0] c,
                          input bit sf, input logic [3:0] cd, input bit ordy);
        in_valid  = v;
        sum       = s;
        carry     = c;
        set_flags = sf;
        cond      = cd;
        out_ready = ordy;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 64'd0, 64'd0, 0, 4'd0, 0);
        ce_cond = 4'd0;
        ce_nzcv = 4'd0;
        tick();
        tick();
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_flags", {60'd0, flags}, 64'd0);
        chk("reset_result", result, 64'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // SUBS giving zero with full carry chain, cond EQ
        set_in(1, 64'd0, {64{1'b1}}, 1, 4'd0, 0);
        tick();
        chk("subs_out_valid", {63'd0, out_valid}, 64'd1);
        chk("subs_flags", {60'd0, flags}, 64'h6);
        chk("subs_cond_true", {63'd0, cond_true}, 64'd1);
        set_in(0, 64'd0, 64'd0, 0, 4'd0, 1);
        tick();

        // ADDS overflow to negative, then non-flag op with LT
        set_in(1, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 1, 4'd14, 1);
        tick();
        chk("adds_flags", {60'd0, flags}, 64'h9);
        set_in(1, 64'd5, 64'd0, 0, 4'd11, 1);
        tick();
        chk("lt_cond_true", {63'd0, cond_true}, 64'd0);
        chk("lt_result", result, 64'd5);
        chk("lt_flags_hold", {60'd0, flags}, 64'h9);
        set_in(0, 64'd0, 64'd0, 0, 4'd0, 1);
        tick();

        // Back-pressure with three back-to-back valids
        set_in(1, 64'h11, 64'd0, 0, 4'd14, 0);
        tick();
        set_in(1, 64'h22, 64'd0, 0, 4'd14, 0);
        tick();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        set_in(1, 64'h33, 64'd0, 0, 4'd14, 0);
        tick();
        chk("stall_result", result, 64'h11);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        set_in(0, 64'd0, 64'd0, 0, 4'd0, 1);
        tick();
        chk("order_second", result, 64'h22);
        tick();
        chk("drained", {63'd0, out_valid}, 64'd0);

        // Simultaneous push and pop at count 1
        set_in(1, 64'hA1, 64'd0, 0, 4'd14, 0);
        tick();
        set_in(1, 64'hB2, 64'd0, 0, 4'd14, 1);
        tick();
        chk("pushpop_result", result, 64'hB2);
        chk("pushpop_in_ready", {63'd0, in_ready}, 64'd1);
        set_in(0, 64'd0, 64'd0, 0, 4'd0, 1);
        tick();

        // Reset with two entries buffered and flags set
        set_in(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 4'd14, 0);
        tick();
        chk("pre_reset_flags", {60'd0, flags}, 64'hB);
        set_in(1, 64'h77, 64'd0, 0, 4'd14, 0);
        tick();
        reset = 1'b1;
        set_in(1, 64'd0, {64{1'b1}}, 1, 4'd0, 0);
        tick();
        chk("mid_reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_reset_flags", {60'd0, flags}, 64'd0);
        chk("mid_reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_reset_result", result, 64'd0);
        reset = 1'b0;
        set_in(0, 64'd0, 64'd0, 0, 4'd0, 0);
        tick();

        // Every condition against every reachable NZCV through the stage
        for (int f = 0; f < 16; f++) begin
            logic [3:0] fv;
            fv = 4'(f);
            if (!(fv[3] && fv[2])) begin
                for (int k = 0; k < 16; k++) begin
                    set_in(1, fv[2] ? 64'd0 : {fv[3], 62'd0, 1'b1},
                           {fv[1], fv[1] ^ fv[0], 62'd0}, 1, 4'(k), 1);
                    tick();
                end
            end
        end

        // Exhaustive condition table on the evaluator alone
        for (int f = 0; f < 16; f++) begin
            for (int k = 0; k < 16; k++) begin
                ce_cond = 4'(k);
                ce_nzcv = 4'(f);
                #1;
                chk($sformatf("cond_table_c%0d_f%0d", k, f), {63'd0, ce_true},
                    {63'd0, ref_cond(k, 4'(f))});
            end
        end

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            set_in($urandom_range(0, 3) != 0,
                   ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                   4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
            tick();
        end
        reset = 1'b0;
        set_in(0, 64'd0, 64'd0, 0, 4'd0, 1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
